// File: rtl/para_sync_fifo_pre.sv
// Synchronous FIFO with selectable read behaviour.
//
// Storage is an inferred block RAM with a registered read port. Fill level is
// tracked in one registered counter (count_q), and every fill flag is a
// decode of that counter, so no input reaches a flag combinationally.
//
// Standard mode (FWFT_EN = 0)
//   An accepted read at edge k reads the RAM into rdata_q at that edge. The
//   word is transferred into the resettable output register at edge k+1, and
//   valid pulses for that one cycle. This two-stage arrangement keeps the RAM
//   output register free of reset and lets dout clear to zero on srst.
//
// FWFT mode (FWFT_EN = 1)
//   dout_q is an output stage that holds the head word, and valid_q marks it
//   as loaded. The RAM is read one pointer ahead (rd_ptr_d) with a
//   write-to-read bypass, so rdata_q always mirrors mem[rd_ptr_q]. That lets
//   the stage reload at the same edge it is consumed, without a bubble.
//   The stage word still counts toward data_count, so capacity stays DEPTH.

module para_sync_fifo_pre #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int FWFT_EN    = 0,
    parameter int PROG_FULL  = 500,
    parameter int PROG_EMPTY = 50
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  prog_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  prog_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_M1_C = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PF_C       = CW'(PROG_FULL);
    localparam logic [ADDR_WIDTH:0] PE_C       = CW'(PROG_EMPTY);
    localparam logic [ADDR_WIDTH:0] ONE_C      = CW'(1);
    localparam logic [ADDR_WIDTH:0] ZERO_C     = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH:0]   wr_ptr_q;
    logic [ADDR_WIDTH:0]   wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q;
    logic [ADDR_WIDTH:0]   rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;

    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;

    // ------------------------------------------------------------------
    // Handshake decode (uses flags as they stood before the edge)
    // ------------------------------------------------------------------
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_adv;   // read pointer advances this edge
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign full_w  = (count_q == DEPTH_C);
    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];

    // srst wins over both requests, so neither side is accepted during reset.
    assign wr_acc = wr_en & ~full_w  & ~srst;
    assign rd_acc = rd_en & ~empty_w & ~srst;

    // ------------------------------------------------------------------
    // Mode-specific read path
    // ------------------------------------------------------------------
    generate
        if (FWFT_EN != 0) begin : g_fwft
            logic [ADDR_WIDTH:0] mem_cnt;   // words in RAM, excluding the stage
            logic                load;      // move head word from RAM into the stage

            assign mem_cnt = wr_ptr_q - rd_ptr_q;
            assign load    = (mem_cnt != ZERO_C) & (~valid_q | rd_acc) & ~srst;
            assign empty_w = ~valid_q;
            assign rd_adv  = load;
            // Read one ahead so rdata_q already holds mem[rd_ptr_q] next cycle.
            assign rd_addr = srst ? '0 : rd_ptr_d[ADDR_WIDTH-1:0];

            // Output stage: reload when drained or consumed, else drop on consume.
            always_comb begin
                dout_d  = dout_q;
                valid_d = valid_q & ~rd_acc;
                if (load) begin
                    dout_d  = rdata_q;
                    valid_d = 1'b1;
                end
            end
        end else begin : g_std
            logic rd_pend_q;   // rdata_q carries a word that goes out next edge

            assign empty_w = (count_q == ZERO_C);
            assign rd_adv  = rd_acc;
            assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

            // Track which RAM reads must be forwarded to dout next edge.
            always_ff @(posedge clk) begin
                if (srst) begin
                    rd_pend_q <= 1'b0;
                end else begin
                    rd_pend_q <= rd_acc;
                end
            end

            // Output register: capture a pending read, hold otherwise.
            always_comb begin
                dout_d  = dout_q;
                valid_d = rd_pend_q;
                if (rd_pend_q) begin
                    dout_d = rdata_q;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointer, count and status next-state
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit and roll over naturally at 2*DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end
    end

    // Count follows accepted accesses only; simultaneous accept leaves it alone.
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Rejected-access indicators for the following cycle.
    always_comb begin
        overflow_d  = wr_en & full_w;
        underflow_d = rd_en & empty_w;
    end

    // ------------------------------------------------------------------
    // Storage: write port plus registered read with write-to-read bypass
    // ------------------------------------------------------------------
    // RAM array, no reset; the bypass makes a same-address read see new data.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= din;
        end
        if (wr_acc && (wr_addr == rd_addr)) begin
            rdata_q <= din;
        end else begin
            rdata_q <= mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // Pointers, count, output stage and status, all cleared by srst.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: flags decoded from registered state only
    // ------------------------------------------------------------------
    assign dout         = dout_q;
    assign valid        = valid_q;
    assign data_count   = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= DEPTH_M1_C);
    assign prog_full    = (count_q >= PF_C);
    assign almost_empty = (count_q <= ONE_C);
    assign prog_empty   = (count_q <= PE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/para_sync_fifo_pre.md
PARA_SYNC_FIFO_PRE -- requirements
Module: para_sync_fifo_pre

Interface
REQ-001 The block SHALL take these parameters, one per line as name, default, meaning:
- DATA_WIDTH, 64, word width.
- ADDR_WIDTH, 9, depth DEPTH = 2^ADDR_WIDTH words.
- FWFT_EN, 0, 0 = standard read, 1 = first-word-fall-through (prefetch).
- PROG_FULL, 500, prog_full threshold (1..DEPTH).
- PROG_EMPTY, 50, prog_empty threshold (0..DEPTH-1).

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, single clock for all logic.
- srst, in, 1, reset (synchronous, active-high).
- din, in, DATA_WIDTH, write data.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request (FWFT: acknowledge of dout).
- dout, out, DATA_WIDTH, read data.
- valid, out, 1, dout holds a freshly read word.
- full, out, 1, no write accepted.
- almost_full, out, 1, at most one free slot.
- prog_full, out, 1, fill level at or above PROG_FULL.
- empty, out, 1, no read accepted.
- almost_empty, out, 1, at most one readable word.
- prog_empty, out, 1, fill level at or below PROG_EMPTY.
- overflow, out, 1, previous-cycle write was rejected.
- underflow, out, 1, previous-cycle read was rejected.
- data_count, out, ADDR_WIDTH+1, words accepted but not yet read.

REQ-003 One clock, clk; reset srst is synchronous and active-high.

Function
REQ-004 A write SHALL be accepted iff wr_en=1 and full=0; a read SHALL be accepted iff rd_en=1 and empty=0; both SHALL use the flag values from before the edge.
REQ-005 Storage SHALL be a circular buffer with read and write pointers of ADDR_WIDTH+1 bits; the MSB distinguishes wrap; pointers SHALL roll over from DEPTH*2-1 to 0.
REQ-006 data_count SHALL be +1 on a write only, -1 on a read only, and unchanged when both or neither are accepted.
REQ-007 When full, a simultaneous wr_en and rd_en SHALL accept only the read: data_count goes DEPTH to DEPTH-1.
REQ-008 When empty, a simultaneous wr_en and rd_en SHALL accept only the write: data_count goes 0 to 1.
REQ-009 Fill flags SHALL be decoded from registered data_count only (no input-to-flag combinational path):
- full = (count==DEPTH)
- almost_full = (count>=DEPTH-1)
- prog_full = (count>=PROG_FULL)
- almost_empty = (count<=1)
- prog_empty = (count<=PROG_EMPTY)
REQ-010 Standard mode (FWFT_EN=0):
- empty = (count==0).
- An accepted read at edge k SHALL load dout at edge k+1 with valid=1 for exactly that cycle.
- dout SHALL hold its value otherwise.
REQ-011 FWFT mode (FWFT_EN=1):
- An output stage SHALL hold the head word; empty=0 and valid=1 whenever that stage is loaded.
- A write into an empty FIFO at edge k SHALL appear on dout with empty=0 after edge k+1.
- An accepted read SHALL advance dout to the next word at the same edge with no bubble when a further word is stored.
- Otherwise empty=1 after that edge.
REQ-012 In FWFT mode, words held in the output stage SHALL be counted in data_count; total capacity stays DEPTH in both modes.
REQ-013 overflow SHALL pulse for one cycle after each edge with wr_en=1 and full=1; underflow likewise for rd_en=1 and empty=1.
REQ-014 A rejected access SHALL not change pointers, count, storage or dout.
REQ-015 Written data SHALL emerge in write order; no word lost or duplicated across wrap-around.

Reset
REQ-016 srst=1 at an edge SHALL set:
- pointers = 0, data_count = 0
- empty = 1, almost_empty = 1, prog_empty = 1
- full = 0, almost_full = 0, prog_full = 0
- valid = 0, overflow = 0, underflow = 0, dout = 0
- FWFT output stage emptied
REQ-017 srst SHALL override wr_en and rd_en in the same cycle, including mid-burst; storage contents need not be cleared.

Verification
REQ-018 ST, ADDR_WIDTH=2: write 4 words A,B,C,D -> full=1, count=4; 5th wr_en -> overflow=1 next cycle, count stays 4; 4 reads -> dout A,B,C,D each one cycle after rd_en, valid pulses; then empty=1.
REQ-019 Full boundary: with count=4, wr_en=rd_en=1 -> count=3, full=0; with count=0, both asserted -> count=1, underflow=1, dout unchanged.
REQ-020 FWFT, ADDR_WIDTH=2: single write 0x5A at edge k -> dout=0x5A, empty=0 after edge k+1; rd_en held with 3 more words queued -> one new word per cycle, no bubble.
REQ-021 Wrap: 10 cycles of continuous simultaneous write/read at count=2 -> pointers wrap twice, output order matches input, count stays 2.
REQ-022 Thresholds, DEPTH=512, PROG_FULL=500, PROG_EMPTY=50:
- prog_empty=1 at count 50, 0 at 51
- prog_full=0 at 499, 1 at 500
- almost_full=1 at 511
REQ-023 srst asserted at count=3 with wr_en=1 -> next cycle count=0, empty=1, valid=0, no write accepted.
